// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared widths, address codes and control-FSM state encodings for the 1x3 router
package router_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
  localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
  localparam logic [2:0] LOAD_DATA          = 3'd2;
  localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd3;
  localparam logic [2:0] FIFO_FULL_STATE    = 3'd4;
  localparam logic [2:0] LOAD_AFTER_FULL    = 3'd5;
  localparam logic [2:0] LOAD_PARITY        = 3'd6;
  localparam logic [2:0] CHECK_PARITY_ERROR = 3'd7;

endpackage

// File: rtl/router_reg_if.sv
// rtl/router_reg_if.sv - source byte, FSM state strobes and register-stage results of the router datapath
interface router_reg_if;
  import router_pkg::*;

  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic [DATA_W-1:0] dout;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              err;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_pkt_valid, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_pkt_valid, err
  );

endinterface

// File: rtl/router_reg.sv
// rtl/router_reg.sv - router datapath register: header latch, FIFO-full hold byte, running parity and error flag
module router_reg
  import router_pkg::*;
(
  input  logic         clock,
  input  logic         resetn,
  router_reg_if.slave  bus
);

  logic [DATA_W-1:0] dout_d, dout_q;
  logic [DATA_W-1:0] header_d, header_q;
  logic [DATA_W-1:0] hold_d, hold_q;
  logic [DATA_W-1:0] int_par_d, int_par_q;
  logic [DATA_W-1:0] pkt_par_d, pkt_par_q;
  logic              parity_done_d, parity_done_q;
  logic              low_pkt_valid_d, low_pkt_valid_q;
  logic              err_d, err_q;

  logic laf_parity;

  // A parity byte parked in hold is only taken once, on the first LOAD_AFTER_FULL after it.
  assign laf_parity = bus.laf_state && low_pkt_valid_q && !parity_done_q;

  always_comb begin
    header_d        = header_q;
    dout_d          = dout_q;
    hold_d          = hold_q;
    int_par_d       = int_par_q;
    pkt_par_d       = pkt_par_q;
    parity_done_d   = parity_done_q;
    low_pkt_valid_d = low_pkt_valid_q;
    err_d           = err_q;

    if (bus.detect_add && bus.pkt_valid && bus.data_in[1:0] != ADDR_INVALID)
      header_d = bus.data_in;

    if (bus.lfd_state)
      dout_d = header_q;
    else if (bus.ld_state && !bus.fifo_full)
      dout_d = bus.data_in;
    else if (bus.laf_state)
      dout_d = hold_q;

    if (bus.ld_state && bus.fifo_full)
      hold_d = bus.data_in;

    // Payload bytes are accumulated on arrival even when parked in hold, so the replay is not counted again.
    if (bus.detect_add)
      int_par_d = '0;
    else if (bus.lfd_state)
      int_par_d = int_par_q ^ header_q;
    else if (bus.ld_state && bus.pkt_valid && !bus.full_state)
      int_par_d = int_par_q ^ bus.data_in;

    if (bus.detect_add)
      pkt_par_d = '0;
    else if (bus.ld_state && !bus.pkt_valid && !bus.fifo_full)
      pkt_par_d = bus.data_in;
    else if (laf_parity)
      pkt_par_d = hold_q;

    if (bus.ld_state && !bus.pkt_valid)
      low_pkt_valid_d = 1'b1;
    else if (bus.rst_int_reg)
      low_pkt_valid_d = 1'b0;

    if (bus.detect_add)
      parity_done_d = 1'b0;
    else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) || laf_parity)
      parity_done_d = 1'b1;

    if (bus.detect_add)
      err_d = 1'b0;
    else if (parity_done_q)
      err_d = (int_par_q != pkt_par_q);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dout_q          <= '0;
      header_q        <= '0;
      hold_q          <= '0;
      int_par_q       <= '0;
      pkt_par_q       <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      dout_q          <= dout_d;
      header_q        <= header_d;
      hold_q          <= hold_d;
      int_par_q       <= int_par_d;
      pkt_par_q       <= pkt_par_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
    end
  end

  assign bus.dout          = dout_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_router_reg.sv
// tb/tb_router_reg.sv - scoreboard bench for router_reg driven by an emulated control FSM
module tb_router_reg;

  typedef struct {
    bit         cd;
    logic [7:0] d;
    bit         cs;
    logic [2:0] s;
    string      nm;
  } exp_t;

  logic clock;
  logic resetn;
  router_reg_if bus();

  router_reg dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  exp_t       exp_q[$];
  exp_t       mon_e;
  bit         chk_flag;
  bit         mon_pend;
  int         checks;
  int         errors;
  logic [7:0] last_hdr;

  // One cycle of stimulus; the optional expectation applies to the outputs after this cycle's edge.
  task automatic drive(input bit da, input bit lfd, input bit ld, input bit laf,
                       input bit fs, input bit rir, input bit pv, input bit ff,
                       input logic [7:0] d, input bit cd, input logic [7:0] ed,
                       input bit cs, input logic [2:0] es, input string nm);
    exp_t e;
    bus.detect_add  = da;
    bus.lfd_state   = lfd;
    bus.ld_state    = ld;
    bus.laf_state   = laf;
    bus.full_state  = fs;
    bus.rst_int_reg = rir;
    bus.pkt_valid   = pv;
    bus.fifo_full   = ff;
    bus.data_in     = d;
    if (cd || cs) begin
      e.cd = cd; e.d = ed; e.cs = cs; e.s = es; e.nm = nm;
      exp_q.push_back(e);
      chk_flag = 1'b1;
    end else begin
      chk_flag = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(0,0,0,0,0,0,0,0, 8'($urandom), 0, 8'h00, 0, 3'b000, "");
  endtask

  // Status triple is {parity_done, low_pkt_valid, err}; bytes on dout must be header, payload..., parity in order.
  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pl[$],
                          input logic [7:0] par, input bit fullm[$]);
    logic [7:0] calc;
    bit         exp_err;
    int         n;
    logic [7:0] b;
    bit         pv;
    calc = hdr;
    foreach (pl[i]) calc = calc ^ pl[i];
    exp_err = (calc != par);
    n = pl.size();
    last_hdr = hdr;
    drive(1,0,0,0,0,0,1,0, hdr, 0, 8'h00, 0, 3'b000, "");
    drive(0,1,0,0,0,0,1,0, 8'($urandom), 1, hdr, 1, 3'b000, "lfd_header");
    for (int i = 0; i <= n; i++) begin
      b  = (i < n) ? pl[i] : par;
      pv = (i < n);
      if (fullm[i]) begin
        drive(0,0,1,0,0,0,pv,1, b, 0, 8'h00, 1, {1'b0, !pv, 1'b0}, "full_hold_status");
        drive(0,0,0,0,1,0,pv,0, b, 0, 8'h00, 0, 3'b000, "");
        drive(0,0,0,1,0,0,pv,0, b, 1, b, 1, {!pv, !pv, 1'b0}, "laf_replay");
      end else begin
        drive(0,0,1,0,0,0,pv,0, b, 1, b, 1, {!pv, !pv, 1'b0}, "ld_byte");
      end
    end
    drive(0,0,0,0,0,0,0,0, 8'($urandom), 1, par, 1, {1'b1, 1'b1, exp_err}, "post_parity");
    drive(0,0,0,0,0,1,0,0, 8'($urandom), 0, 8'h00, 1, {1'b1, 1'b0, exp_err}, "check_parity");
  endtask

  task automatic invalid_addr(input logic [7:0] bad);
    drive(1,0,0,0,0,0,1,0, bad, 0, 8'h00, 0, 3'b000, "");
    drive(0,1,0,0,0,0,1,0, 8'($urandom), 1, last_hdr, 1, 3'b000, "invalid_addr_header");
    idle(1);
  endtask

  always @(posedge clock) mon_pend = chk_flag;

  always @(negedge clock) begin
    if (mon_pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: output check with no expectation queued");
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cd) begin
          checks++;
          if (bus.dout !== mon_e.d) begin
            errors++;
            $display("FAIL %s dout: got %h expected %h", mon_e.nm, bus.dout, mon_e.d);
          end
        end
        if (mon_e.cs) begin
          checks++;
          if ({bus.parity_done, bus.low_pkt_valid, bus.err} !== mon_e.s) begin
            errors++;
            $display("FAIL %s {parity_done,low_pkt_valid,err}: got %b expected %b",
                     mon_e.nm, {bus.parity_done, bus.low_pkt_valid, bus.err}, mon_e.s);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] pl[$];
    bit         fm[$];
    logic [7:0] hdr, good, par, tmp;
    int         n;
    checks   = 0;
    errors   = 0;
    chk_flag = 1'b0;
    last_hdr = 8'h00;
    resetn   = 1'b0;
    drive(0,0,1,0,0,0,1,0, 8'hFF, 1, 8'h00, 1, 3'b000, "reset");
    drive(0,0,1,0,0,0,1,0, 8'hFF, 1, 8'h00, 1, 3'b000, "reset");
    resetn = 1'b1;
    idle(1);

    pl = '{8'hA3}; fm = '{0, 0};
    send_pkt(8'h05, pl, 8'hA6, fm);
    idle(1);
    send_pkt(8'h05, pl, 8'h00, fm);
    idle(2);
    pl = '{8'h11, 8'h22}; fm = '{0, 1, 0};
    send_pkt(8'h09, pl, 8'h3A, fm);
    pl = '{8'hA3}; fm = '{0, 1};
    send_pkt(8'h05, pl, 8'hA6, fm);
    pl = '{}; fm = '{0};
    send_pkt(8'h06, pl, 8'h06, fm);
    invalid_addr(8'h07);

    // Reset mid-packet: header and outputs are all discarded.
    drive(1,0,0,0,0,0,1,0, 8'h12, 0, 8'h00, 0, 3'b000, "");
    drive(0,1,0,0,0,0,1,0, 8'h34, 0, 8'h00, 0, 3'b000, "");
    drive(0,0,1,0,0,0,1,0, 8'h34, 0, 8'h00, 0, 3'b000, "");
    resetn = 1'b0;
    drive(0,0,1,0,0,0,0,0, 8'h55, 1, 8'h00, 1, 3'b000, "mid_packet_reset");
    resetn = 1'b1;
    last_hdr = 8'h00;
    invalid_addr(8'hFB);

    for (int k = 0; k < 40; k++) begin
      tmp = 8'($urandom);
      hdr = {tmp[7:2], 2'($urandom_range(0, 2))};
      n = $urandom_range(0, 5);
      pl = '{};
      fm = '{};
      good = hdr;
      for (int i = 0; i < n; i++) begin
        tmp = 8'($urandom);
        pl.push_back(tmp);
        good = good ^ tmp;
      end
      for (int i = 0; i <= n; i++) fm.push_back($urandom_range(0, 3) == 0);
      par = ($urandom_range(0, 1) == 1) ? good : 8'($urandom);
      send_pkt(hdr, pl, par, fm);
      if ($urandom_range(0, 9) == 0) begin
        tmp = 8'($urandom);
        invalid_addr({tmp[7:2], 2'b11});
      end
      idle($urandom_range(0, 2));
    end

    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
